// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave with a DEPTH-word storage bank and WAIT_CYC wait states.
// Addresses at or above DEPTH complete with pslverr and never touch storage.
// Optional write protection of addresses >= WP_BASE: define APB_SLAVE_WPROT_EN.
//
//   state  | meaning
//   IDLE   | no transfer in flight, waiting for a setup phase
//   ACCESS | transfer latched, counting wait states, then completing
module apb_slave_mem #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 1,
  parameter int WP_BASE  = 48
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] padd,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYC);
  localparam logic            WAIT0   = (WAIT_CYC == 0);
`ifdef APB_SLAVE_WPROT_EN
  localparam logic [ADDR_W:0] WP_L    = (ADDR_W+1)'(WP_BASE);
`endif

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              write;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] resp_addr;
  logic              resp_write;
  logic              resp_err;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_val;

  // Response decode: with zero wait states the response is formed from the
  // live setup-phase inputs, otherwise from the latched transfer.
  always_comb begin
    resp_addr  = (state == IDLE) ? padd : addr;
    resp_write = (state == IDLE) ? pwrite : write;
    idx        = resp_addr[IDX_W-1:0];
    resp_err   = ({1'b0, resp_addr} >= DEPTH_L);
`ifdef APB_SLAVE_WPROT_EN
    if (resp_write && ({1'b0, resp_addr} >= WP_L))
      resp_err = 1'b1;
`endif
    rd_val = ({1'b0, resp_addr} < DEPTH_L) ? mem[idx] : '0;
  end

  // Transfer FSM, wait-state down-counter, registered response and storage.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      cnt     <= '0;
      addr    <= '0;
      write   <= 1'b0;
      wdata   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          if (psel && !penable) begin
            addr   <= padd;
            write  <= pwrite;
            wdata  <= pwdata;
            cnt    <= WAIT_L;
            state  <= ACCESS;
            pready <= WAIT0;
            if (WAIT0) begin
              pslverr <= resp_err;
              if (!resp_write) prdata <= rd_val;
            end
          end
        end
        ACCESS: begin
          if (pready) begin
            if (psel && penable && write && !resp_err) mem[idx] <= wdata;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            state   <= IDLE;
          end else if (!psel) begin
            // master abandoned the transfer: drop it without side effects
            pready <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt    <= cnt - 4'd1;
            pready <= (cnt == 4'd1);
            if (cnt == 4'd1) begin
              pslverr <= resp_err;
              if (!write) prdata <= rd_val;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed bench for apb_slave_mem with three instances
// (WAIT_CYC = 1, 0 and 3) sharing one clock and with separate resets.
module tb_apb_slave_mem;

  logic       pclk = 1'b0;
  logic       preset  [3];
  logic       psel    [3];
  logic       penable [3];
  logic       pwrite  [3];
  logic [7:0] padd    [3];
  logic [7:0] pwdata  [3];
  logic       pready  [3];
  logic [7:0] prdata  [3];
  logic       pslverr [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(.WAIT_CYC(1)) dut_w1 (
    .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .padd(padd[0]), .pwdata(pwdata[0]),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

  apb_slave_mem #(.WAIT_CYC(0)) dut_w0 (
    .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .padd(padd[1]), .pwdata(pwdata[1]),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

  apb_slave_mem #(.WAIT_CYC(3)) dut_w3 (
    .pclk(pclk), .preset(preset[2]), .psel(psel[2]), .penable(penable[2]),
    .pwrite(pwrite[2]), .padd(padd[2]), .pwdata(pwdata[2]),
    .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // One transfer; n is the access-cycle index in which pready was seen.
  // Leaves psel/penable high so a following call runs back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic er, output int n);
    @(negedge pclk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; padd[d] = a; pwdata[d] = wd;
    @(negedge pclk);
    penable[d] = 1'b1;
    n = 0;
    while (!pready[d] && n < 20) begin
      @(negedge pclk);
      n++;
    end
    rd = prdata[d];
    er = pslverr[d];
  endtask

  task automatic run(input string tag, input int d, input logic wr, input logic [7:0] a,
                     input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_err,
                     input int exp_n);
    logic [7:0] rd;
    logic       er;
    int         n;
    xfer(d, wr, a, wd, rd, er, n);
    chk({tag, "_wait"}, n, exp_n);
    chk({tag, "_err"}, er, exp_err);
    if (!wr) chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  task automatic idle(input int d);
    @(negedge pclk);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         n;

    for (int i = 0; i < 3; i++) begin
      preset[i] = 1'b1; psel[i] = 1'b0; penable[i] = 1'b0;
      pwrite[i] = 1'b0; padd[i] = '0; pwdata[i] = '0;
    end
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 3; i++) preset[i] = 1'b0;
    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pready%0d", i), pready[i], 1'b0);
      chk($sformatf("rst_pslverr%0d", i), pslverr[i], 1'b0);
      chk($sformatf("rst_prdata%0d", i), prdata[i], 8'h00);
    end

    // WAIT_CYC = 1: read after reset, ready in access cycle 1
    run("rd00", 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1);
    idle(0);
    chk("rd00_pready_drop", pready[0], 1'b0);

    run("wr2a", 0, 1'b1, 8'h2A, 8'hA5, 8'h00, 1'b0, 1);
    run("rd2a", 0, 1'b0, 8'h2A, 8'h00, 8'hA5, 1'b0, 1);
    idle(0);

    // out of range: errors, prdata held across the failed write, no aliasing
    xfer(0, 1'b1, 8'hCC, 8'h5A, rd, er, n);
    chk("wrcc_err", er, 1'b1);
    chk("wrcc_prdata_hold", rd, 8'hA5);
    run("rdcc", 0, 1'b0, 8'hCC, 8'h00, 8'h00, 1'b1, 1);
    run("rd0c_alias", 0, 1'b0, 8'h0C, 8'h00, 8'h00, 1'b0, 1);
    run("rd2a_again", 0, 1'b0, 8'h2A, 8'h00, 8'hA5, 1'b0, 1);
    idle(0);

    // penable high in IDLE must not start a transfer
    @(negedge pclk);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; padd[0] = 8'h01; pwdata[0] = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk($sformatf("viol_pready%0d", i), pready[0], 1'b0);
    end
    idle(0);
    run("rd01_viol", 0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1);
    idle(0);

    // WAIT_CYC = 0: back-to-back write then read
    run("w0_wr05", 1, 1'b1, 8'h05, 8'h11, 8'h00, 1'b0, 0);
    run("w0_rd05", 1, 1'b0, 8'h05, 8'h00, 8'h11, 1'b0, 0);
    idle(1);
    chk("w0_pready_drop", pready[1], 1'b0);

    // WAIT_CYC = 3: abort after one access cycle
    @(negedge pclk);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; padd[2] = 8'h10; pwdata[2] = 8'h77;
    @(negedge pclk);
    penable[2] = 1'b1;
    @(negedge pclk);
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(negedge pclk);
    chk("abort_pready", pready[2], 1'b0);
    run("abort_rd10", 2, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 3);
    run("w3_wr2a", 2, 1'b1, 8'h2A, 8'hA5, 8'h00, 1'b0, 3);
    run("w3_rd2a", 2, 1'b0, 8'h2A, 8'h00, 8'hA5, 1'b0, 3);
    idle(2);

    // reset pulsed during a read's wait states
    @(negedge pclk);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b0; padd[2] = 8'h2A;
    @(negedge pclk);
    penable[2] = 1'b1;
    @(negedge pclk);
    preset[2] = 1'b1;
    @(negedge pclk);
    chk("midrst_pready", pready[2], 1'b0);
    chk("midrst_prdata", prdata[2], 8'h00);
    preset[2] = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
    run("midrst_rd2a", 2, 1'b0, 8'h2A, 8'h00, 8'h00, 1'b0, 3);
    idle(2);

`ifdef APB_SLAVE_WPROT_EN
    run("wp_wr30", 0, 1'b1, 8'h30, 8'h3C, 8'h00, 1'b1, 1);
    run("wp_rd30", 0, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0, 1);
    run("wp_wr2f", 0, 1'b1, 8'h2F, 8'h3C, 8'h00, 1'b0, 1);
    run("wp_rd2f", 0, 1'b0, 8'h2F, 8'h00, 8'h3C, 1'b0, 1);
    idle(0);
`endif

    repeat (2) @(negedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
